// File: rtl/trace_capture_pkg.sv
// Shared state encoding, default geometry and pointer helper for the trace capture block.
package trace_package;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      DUMP  = 3'd4,
      DONE  = 3'd5
   } trace_state_t;

   localparam int unsigned DEFAULT_DEPTH    = 16;
   localparam int unsigned DEFAULT_PRE_TRIG = 4;

   // depth is always a power of two, so wrapping is a mask
   function automatic int unsigned wrap_ptr(input int unsigned ptr, input int unsigned depth);
      return ptr & (depth - 1);
   endfunction

endpackage

// File: rtl/trace_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port, no array reset.
module trace_capture_ram #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/trace_capture.sv
// Decimated pre/post-trigger sample capture into a circular buffer, streamed out over valid/ready.
module trace_capture
   import trace_package::*;
#(
   parameter int unsigned N_CH       = 2,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned TIME_WIDTH = 32,
   parameter int unsigned DEPTH      = DEFAULT_DEPTH,
   parameter int unsigned PRE_TRIG   = DEFAULT_PRE_TRIG
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       arm,
   input  logic [15:0]                decim,
   input  logic                       sample_valid,
   input  logic [TIME_WIDTH-1:0]      sample_time,
   input  logic [N_CH*DATA_WIDTH-1:0] sample_data,
   input  logic                       trig_in,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [TIME_WIDTH-1:0]      rd_time,
   output logic [N_CH*DATA_WIDTH-1:0] rd_data,
   output logic                       rd_last,
   output logic                       triggered,
   output logic                       done,
   output logic [2:0]                 state
);

   localparam int unsigned AW     = $clog2(DEPTH);
   localparam int unsigned CW     = AW + 1;
   localparam int unsigned EW     = TIME_WIDTH + N_CH * DATA_WIDTH;
   localparam int unsigned POST_N = DEPTH - PRE_TRIG;

   trace_state_t  fsm;
   logic [15:0]   dcnt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] fill_cnt, rd_cnt;
   logic          arm_ok, accept, capturing, we, re, pop, fin;
   logic [EW-1:0] ram_q, sk_entry;
   logic          rq_valid, rq_last, sk_valid, sk_last;
   logic [1:0]    occ;

   assign arm_ok    = arm && (fsm != DUMP);
   assign accept    = sample_valid && (dcnt == '0);
   assign capturing = (fsm == PRE) || (fsm == ARMED) || (fsm == POST);
   assign we        = accept && capturing && !arm_ok;
   assign pop       = rd_valid && rd_ready;
   assign fin       = pop && rd_last;
   assign state     = fsm;

   // Entries held after this cycle; a read issued now must find a free slot next cycle.
   assign occ = 2'(rd_valid) + 2'(sk_valid) + 2'(rq_valid) - 2'(pop);
   assign re  = (fsm == DUMP) && (rd_cnt < CW'(DEPTH)) && (occ <= 2'd1);

   trace_capture_ram #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr),
      .wdata ({sample_time, sample_data}),
      .re    (re),
      .raddr (rd_ptr),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            dcnt <= '0;
      else if (arm_ok)       dcnt <= '0;
      else if (sample_valid) dcnt <= (dcnt >= decim) ? '0 : dcnt + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill_cnt  <= '0;
         rd_cnt    <= '0;
         triggered <= 1'b0;
         done      <= 1'b0;
      end else if (arm_ok) begin
         fsm       <= PRE;
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         triggered <= 1'b0;
         done      <= 1'b0;
      end else begin
         if (we) wr_ptr <= AW'(wrap_ptr(32'(wr_ptr) + 32'd1, DEPTH));
         case (fsm)
            PRE: if (we) begin
               if (fill_cnt == CW'(PRE_TRIG - 1)) begin
                  fsm      <= ARMED;
                  fill_cnt <= '0;
               end else begin
                  fill_cnt <= fill_cnt + CW'(1);
               end
            end
            ARMED: if (we && trig_in) begin
               triggered <= 1'b1;
               rd_ptr    <= AW'(wrap_ptr(32'(wr_ptr) + DEPTH - PRE_TRIG, DEPTH));
               rd_cnt    <= '0;
               fill_cnt  <= CW'(1);
               fsm       <= (POST_N == 1) ? DUMP : POST;
            end
            POST: if (we) begin
               fill_cnt <= fill_cnt + CW'(1);
               if (fill_cnt == CW'(POST_N - 1)) fsm <= DUMP;
            end
            DUMP: begin
               if (re) begin
                  rd_ptr <= AW'(wrap_ptr(32'(rd_ptr) + 32'd1, DEPTH));
                  rd_cnt <= rd_cnt + CW'(1);
               end
               if (fin) begin
                  fsm  <= DONE;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // RAM output lands in the output register when it is free, otherwise in the skid slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq_valid <= 1'b0;
         rq_last  <= 1'b0;
         sk_valid <= 1'b0;
         sk_last  <= 1'b0;
         sk_entry <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_time  <= '0;
         rd_data  <= '0;
      end else if (fsm != DUMP || fin) begin
         rq_valid <= 1'b0;
         sk_valid <= 1'b0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         rq_valid <= re;
         rq_last  <= re && (rd_cnt == CW'(DEPTH - 1));
         if (!rd_valid || pop) begin
            if (sk_valid) begin
               {rd_time, rd_data} <= sk_entry;
               rd_last  <= sk_last;
               rd_valid <= 1'b1;
               sk_valid <= rq_valid;
               sk_entry <= ram_q;
               sk_last  <= rq_last;
            end else begin
               rd_valid <= rq_valid;
               rd_last  <= rq_last;
               if (rq_valid) {rd_time, rd_data} <= ram_q;
            end
         end else if (rq_valid) begin
            sk_valid <= 1'b1;
            sk_entry <= ram_q;
            sk_last  <= rq_last;
         end
      end
   end

endmodule

// File: doc/trace_capture.md
# trace_capture

Synthesizable multi-channel successor to the simulation-only transmit logger. Records decimated (timestamp, channel-data) samples from the emulated link datapath into a circular on-chip buffer. Freezes a window of PRE_TRIG samples before a trigger and DEPTH−PRE_TRIG samples from the trigger onward. Streams the window out over a valid/ready port to the host readout path.

## Interface
- N_CH, 2: number of data channels captured per sample
- DATA_WIDTH, 16: bits per channel (signed fixed-point, same format as the filter input)
- TIME_WIDTH, 32: timestamp width (same fixed-point format as emulator time)
- DEPTH, 16: buffer entries; power of two, ≥4
- PRE_TRIG, 4: pre-trigger entries; 1 ≤ PRE_TRIG < DEPTH

- clk  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- arm  in  1  single-cycle pulse; starts or restarts a capture
- decim  in  16  keep one of every decim+1 valid samples
- sample_valid  in  1  sample present this cycle
- sample_time  in  TIME_WIDTH  sample timestamp
- sample_data  in  N_CH*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- trig_in  in  1  trigger qualifier, sampled only with an accepted sample
- rd_valid  out  1  readout entry valid
- rd_ready  in  1  consumer ready
- rd_time  out  TIME_WIDTH  entry timestamp
- rd_data  out  N_CH*DATA_WIDTH  entry channel data
- rd_last  out  1  final entry of window
- triggered  out  1  trigger seen in current capture
- done  out  1  window fully read out
- state  out  3  current FSM state encoding

## Operation
- Accepted sample: sample_valid high and the decimation counter is 0. The counter advances on each valid sample, wraps after decim, and clears on arm. decim=0 accepts every valid sample.
- States: IDLE, PRE, ARMED, POST, DUMP, DONE.
- IDLE/DONE + arm → PRE. Clears wr_ptr, fill count, triggered and done.
- PRE: write each accepted sample at wr_ptr, wr_ptr++ mod DEPTH. After PRE_TRIG writes → ARMED. trig_in is ignored in PRE.
- ARMED: write accepted samples circularly. An accepted sample with trig_in=1 is written as the first post-trigger entry. Record trig_ptr = its address, set triggered, → POST.
- POST: write accepted samples. After DEPTH−PRE_TRIG post-trigger entries in total (including the trigger sample) → DUMP. rd_ptr starts at (trig_ptr − PRE_TRIG) mod DEPTH.
- DUMP: emit exactly DEPTH entries in time order. rd_ptr wraps mod DEPTH. rd_last accompanies entry DEPTH−1. The handshake completing with rd_last → DONE.
- arm in PRE/ARMED/POST restarts the capture (same as from IDLE). arm in DUMP is ignored.
- Samples arriving in IDLE, DUMP and DONE are dropped. The decimation counter still runs in these states.
- Stored fields are copied bit-exact; no arithmetic on data or time.

## Timing
- Reset values: state=IDLE, rd_valid=0, rd_last=0, triggered=0, done=0, rd_time=0, rd_data=0. All pointers and counters are 0.
- Write: an accepted sample is written on the same clk edge. A state transition caused by that sample takes effect on that edge.
- Readout: registered RAM read. rd_valid rises 2 cycles after entry to DUMP. With rd_ready held high, one entry is transferred per cycle with no bubbles, which requires a one-entry prefetch/skid register.
- While rd_valid=1 and rd_ready=0, rd_time, rd_data and rd_last hold stable.
- rd_valid=0 when not in DUMP. done=1 for the whole DONE state.
- rst_n assertion mid-operation: immediate return to reset values, with buffer contents don't-care. The next arm behaves as a fresh capture.

## Structure
- Shared package trace_package: state enum, default DEPTH/PRE_TRIG constants, and a helper function for pointer wrap.
- Sub-module trace_capture_ram: simple dual-port, 1 write and 1 registered read, width TIME_WIDTH+N_CH*DATA_WIDTH, depth DEPTH, no reset on the array.

## Test plan
Default parameters; sample k carries time=k and ch0=k, ch1=−k.
- Basic: arm, decim=0, continuous valid, trig_in only at k=10, rd_ready=1 → times 6..21 output, rd_last with 21, done=1 afterwards.
- Decimation: decim=2, trig at the accepted sample with time 30 → 16 entries with times stepping by 3, window 18..63.
- Early trigger: trig at k=2 (in PRE), trig again at k=7 → window 3..18; trigger at 2 ignored.
- Wrap: trigger at k=40 → window 36..51 with correct order across the address wrap.
- Backpressure: rd_ready random ~50% → identical 16-entry sequence, no drops or duplicates, outputs stable while stalled.
- Reset/restart: rst_n low mid-POST → all outputs at reset values. A new arm with trigger at k=10 → correct window. arm during DUMP is ignored.
